// File: rtl/phase_addr_gen.sv
// Phase-accumulator address generator for a dual-port sine ROM, with linear chirp
// sweep and wrap-aligned phase-offset updates for the second ROM channel.
module phase_addr_gen #(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned ACC_WIDTH     = 16,
    parameter int unsigned LEN_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ACC_WIDTH-1:0]     incr,
    input  logic [ADDRESS_WIDTH-1:0] offset_in,
    input  logic                     offset_ld,
    input  logic                     sweep_start,
    input  logic [ACC_WIDTH-1:0]     sweep_step,
    input  logic [LEN_WIDTH-1:0]     sweep_len,
    output logic [ADDRESS_WIDTH-1:0] addr,
    output logic [ADDRESS_WIDTH-1:0] offset,
    output logic                     wrap,
    output logic                     sweep_busy,
    output logic                     sweep_done
);

    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    state_e                   state_q, state_d;
    logic [ACC_WIDTH-1:0]     acc_q, acc_d;
    logic [ACC_WIDTH-1:0]     freq_q, freq_d;
    logic [LEN_WIDTH-1:0]     cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] offset_q, offset_d;
    logic [ADDRESS_WIDTH-1:0] pend_val_q, pend_val_d;
    logic                     pend_q, pend_d;
    logic                     wrap_q, wrap_d;
    logic                     done_q, done_d;

    logic [ACC_WIDTH-1:0]     step;
    logic [ACC_WIDTH-1:0]     acc_sum;
    logic                     carry;
    logic [ACC_WIDTH:0]       freq_sum;
    logic [ACC_WIDTH-1:0]     freq_sat;

    always_comb begin
        step              = (state_q == StSweep) ? freq_q : incr;
        {carry, acc_sum}  = {1'b0, acc_q} + {1'b0, step};
        freq_sum          = {1'b0, freq_q} + {1'b0, sweep_step};
        freq_sat          = freq_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : freq_sum[ACC_WIDTH-1:0];
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        freq_d     = freq_q;
        cnt_d      = cnt_q;
        offset_d   = offset_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        wrap_d     = 1'b0;
        done_d     = 1'b0;

        if (en) begin
            acc_d  = acc_sum;
            wrap_d = carry;

            unique case (state_q)
                StIdle: begin
                    if (sweep_start) begin
                        freq_d  = incr;
                        cnt_d   = sweep_len;
                        state_d = StSweep;
                    end
                end
                StSweep: begin
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        freq_d = freq_sat;
                        cnt_d  = cnt_q - LEN_WIDTH'(1);
                    end
                end
                default: state_d = StIdle;
            endcase

            // Apply the old pending value at wrap first; a same-cycle load re-arms pend.
            if (carry && pend_q) begin
                offset_d = pend_val_q;
                pend_d   = 1'b0;
            end
            if (offset_ld) begin
                pend_d     = 1'b1;
                pend_val_d = offset_in;
            end
        end else if (offset_ld) begin
            // Generator stopped: no phase glitch possible, apply at once.
            offset_d = offset_in;
            pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            freq_q     <= '0;
            cnt_q      <= '0;
            offset_q   <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            wrap_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            freq_q     <= freq_d;
            cnt_q      <= cnt_d;
            offset_q   <= offset_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            wrap_q     <= wrap_d;
            done_q     <= done_d;
        end
    end

    assign addr       = acc_q[ACC_WIDTH-1 -: ADDRESS_WIDTH];
    assign offset     = offset_q;
    assign wrap       = wrap_q;
    assign sweep_busy = (state_q == StSweep);
    assign sweep_done = done_q;

endmodule

// File: tb/tb_phase_addr_gen.sv
// Directed, table-driven bench for phase_addr_gen with hand-computed expectations.
module tb_phase_addr_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] incr;
    logic [7:0]  offset_in;
    logic        offset_ld;
    logic        sweep_start;
    logic [15:0] sweep_step;
    logic [7:0]  sweep_len;
    logic [7:0]  addr;
    logic [7:0]  offset;
    logic        wrap;
    logic        sweep_busy;
    logic        sweep_done;

    phase_addr_gen #(
        .ADDRESS_WIDTH(8),
        .ACC_WIDTH    (16),
        .LEN_WIDTH    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .incr       (incr),
        .offset_in  (offset_in),
        .offset_ld  (offset_ld),
        .sweep_start(sweep_start),
        .sweep_step (sweep_step),
        .sweep_len  (sweep_len),
        .addr       (addr),
        .offset     (offset),
        .wrap       (wrap),
        .sweep_busy (sweep_busy),
        .sweep_done (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [15:0] incr;
        logic        ld;
        logic [7:0]  oin;
        logic        start;
        logic [15:0] step;
        logic [7:0]  len;
        logic [7:0]  e_addr;
        logic [7:0]  e_off;
        logic        e_wrap;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic vec(input logic e, input logic [15:0] inc, input logic ld,
                       input logic [7:0] oin, input logic st, input logic [15:0] stp,
                       input logic [7:0] ln, input logic [7:0] ea, input logic [7:0] eo,
                       input logic ew, input logic eb, input logic ed);
        vec_t v;
        v.en = e; v.incr = inc; v.ld = ld; v.oin = oin; v.start = st;
        v.step = stp; v.len = ln; v.e_addr = ea; v.e_off = eo;
        v.e_wrap = ew; v.e_busy = eb; v.e_done = ed;
        vq.push_back(v);
    endtask

    task automatic clear_inputs();
        en = 1'b0; incr = '0; offset_in = '0; offset_ld = 1'b0;
        sweep_start = 1'b0; sweep_step = '0; sweep_len = '0;
    endtask

    // Called between clock edges.
    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] acc_exp;
        rst = 1'b0;
        clear_inputs();
        #12;
        check("rst_addr", 0, addr, 0);
        check("rst_offset", 0, offset, 0);
        check("rst_wrap", 0, wrap, 0);
        check("rst_busy", 0, sweep_busy, 0);
        check("rst_done", 0, sweep_done, 0);
        rst = 1'b1;

        // Linear run: addr counts 1..0xFF, 0x00 (wrap), 1..4.
        en = 1'b1; incr = 16'h0100;
        for (int k = 1; k <= 260; k++) begin
            tick();
            check("lin_addr", k, addr, k & 'hFF);
            check("lin_wrap", k, wrap, (k == 256) ? 1 : 0);
        end

        // Half-step frequency with en dropped; acc starts at 0x0400.
        incr = 16'h0080;
        for (int j = 1; j <= 6; j++) begin
            tick();
            acc_exp = 16'h0400 + 16'(j * 'h80);
            check("half_addr", j, addr, acc_exp[15:8]);
        end
        en = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            check("frz_addr", j, addr, 'h07);
            check("frz_wrap", j, wrap, 0);
        end
        en = 1'b1;
        for (int j = 7; j <= 8; j++) begin
            tick();
            acc_exp = 16'h0400 + 16'(j * 'h80);
            check("resume_addr", j, addr, acc_exp[15:8]);
        end

        // Deferred offset load: captured at addr 0x10, applied on the wrap edge.
        clear_inputs();
        do_reset();
        en = 1'b1; incr = 16'h0100;
        for (int k = 1; k <= 16; k++) tick();
        check("off_pre_addr", 16, addr, 'h10);
        offset_ld = 1'b1; offset_in = 8'h40;
        for (int k = 17; k <= 257; k++) begin
            tick();
            offset_ld = 1'b0;
            if (k == 17 || k >= 255) begin
                check("def_off", k, offset, (k >= 256) ? 'h40 : 0);
                check("def_wrap", k, wrap, (k == 256) ? 1 : 0);
            end
        end

        // Table section, from reset.
        clear_inputs();
        do_reset();
        //  en incr     ld oin    st step     len  addr   off    w  b  d
        vec(1, 'h4000, 1, 'h20, 0, 'h0000, 0, 'h40, 'h00, 0, 0, 0);
        vec(1, 'h4000, 1, 'h30, 0, 'h0000, 0, 'h80, 'h00, 0, 0, 0);
        vec(1, 'h4000, 0, 'h00, 0, 'h0000, 0, 'hC0, 'h00, 0, 0, 0);
        vec(1, 'h4000, 0, 'h00, 0, 'h0000, 0, 'h00, 'h30, 1, 0, 0);
        vec(1, 'h4000, 0, 'h00, 0, 'h0000, 0, 'h40, 'h30, 0, 0, 0);
        vec(1, 'h4000, 1, 'h11, 0, 'h0000, 0, 'h80, 'h30, 0, 0, 0);
        vec(1, 'h4000, 0, 'h00, 0, 'h0000, 0, 'hC0, 'h30, 0, 0, 0);
        vec(1, 'h4000, 1, 'h22, 0, 'h0000, 0, 'h00, 'h11, 1, 0, 0);
        vec(1, 'h4000, 0, 'h00, 0, 'h0000, 0, 'h40, 'h11, 0, 0, 0);
        vec(1, 'h4000, 0, 'h00, 0, 'h0000, 0, 'h80, 'h11, 0, 0, 0);
        vec(1, 'h4000, 0, 'h00, 0, 'h0000, 0, 'hC0, 'h11, 0, 0, 0);
        vec(1, 'h4000, 0, 'h00, 0, 'h0000, 0, 'h00, 'h22, 1, 0, 0);
        vec(1, 'h4000, 0, 'h00, 0, 'h0000, 0, 'h40, 'h22, 0, 0, 0);
        vec(1, 'h4000, 0, 'h00, 0, 'h0000, 0, 'h80, 'h22, 0, 0, 0);
        vec(1, 'h4000, 0, 'h00, 0, 'h0000, 0, 'hC0, 'h22, 0, 0, 0);
        vec(1, 'h4000, 0, 'h00, 0, 'h0000, 0, 'h00, 'h22, 1, 0, 0);
        vec(0, 'h4000, 1, 'h55, 0, 'h0000, 0, 'h00, 'h55, 0, 0, 0);
        vec(0, 'h4000, 0, 'h00, 0, 'h0000, 0, 'h00, 'h55, 0, 0, 0);
        vec(1, 'h4000, 1, 'h66, 0, 'h0000, 0, 'h40, 'h55, 0, 0, 0);
        vec(0, 'h4000, 1, 'h77, 0, 'h0000, 0, 'h40, 'h77, 0, 0, 0);
        vec(1, 'h4000, 0, 'h00, 0, 'h0000, 0, 'h80, 'h77, 0, 0, 0);
        vec(1, 'h4000, 0, 'h00, 0, 'h0000, 0, 'hC0, 'h77, 0, 0, 0);
        vec(1, 'h4000, 0, 'h00, 0, 'h0000, 0, 'h00, 'h77, 1, 0, 0);
        // Sweep len=3, step 0x100; start held on the first SWEEP cycle is ignored.
        vec(1, 'h0100, 0, 'h00, 1, 'h0100, 3, 'h01, 'h77, 0, 1, 0);
        vec(1, 'h0000, 0, 'h00, 1, 'h0100, 3, 'h02, 'h77, 0, 1, 0);
        vec(1, 'h0000, 0, 'h00, 0, 'h0100, 3, 'h04, 'h77, 0, 1, 0);
        vec(1, 'h0000, 0, 'h00, 0, 'h0100, 3, 'h07, 'h77, 0, 1, 0);
        vec(1, 'h0000, 0, 'h00, 0, 'h0100, 3, 'h0B, 'h77, 0, 0, 1);
        vec(1, 'h0100, 0, 'h00, 0, 'h0100, 3, 'h0C, 'h77, 0, 0, 0);
        vec(0, 'h0100, 0, 'h00, 1, 'h0100, 3, 'h0C, 'h77, 0, 0, 0);
        vec(1, 'h0100, 0, 'h00, 0, 'h0100, 3, 'h0D, 'h77, 0, 0, 0);
        // Saturating sweep: 0xFF00 + 0x200 clamps to 0xFFFF.
        vec(1, 'hFF00, 0, 'h00, 1, 'h0200, 2, 'h0C, 'h77, 1, 1, 0);
        vec(1, 'h0000, 0, 'h00, 0, 'h0200, 2, 'h0B, 'h77, 1, 1, 0);
        vec(1, 'h0000, 0, 'h00, 0, 'h0200, 2, 'h0A, 'h77, 1, 1, 0);
        vec(1, 'h0000, 0, 'h00, 0, 'h0200, 2, 'h0A, 'h77, 1, 0, 1);
        vec(1, 'h0000, 0, 'h00, 0, 'h0200, 2, 'h0A, 'h77, 0, 0, 0);
        // len=0 exits on the first SWEEP cycle.
        vec(1, 'h0100, 0, 'h00, 1, 'h0100, 0, 'h0B, 'h77, 0, 1, 0);
        vec(1, 'h0000, 0, 'h00, 0, 'h0100, 0, 'h0C, 'h77, 0, 0, 1);
        vec(1, 'h0000, 0, 'h00, 0, 'h0100, 0, 'h0C, 'h77, 0, 0, 0);

        foreach (vq[i]) begin
            en = vq[i].en; incr = vq[i].incr; offset_ld = vq[i].ld;
            offset_in = vq[i].oin; sweep_start = vq[i].start;
            sweep_step = vq[i].step; sweep_len = vq[i].len;
            tick();
            check("tbl_addr", i, addr, vq[i].e_addr);
            check("tbl_offset", i, offset, vq[i].e_off);
            check("tbl_wrap", i, wrap, vq[i].e_wrap);
            check("tbl_busy", i, sweep_busy, vq[i].e_busy);
            check("tbl_done", i, sweep_done, vq[i].e_done);
        end

        // Asynchronous reset mid-sweep with a pending offset.
        clear_inputs();
        en = 1'b1; incr = 16'h0100; sweep_start = 1'b1; sweep_len = 8'd10;
        tick();
        sweep_start = 1'b0; offset_ld = 1'b1; offset_in = 8'h99;
        tick();
        offset_ld = 1'b0;
        tick();
        check("pre_rst_busy", 0, sweep_busy, 1);
        rst = 1'b0;
        #1;
        check("arst_addr", 0, addr, 0);
        check("arst_offset", 0, offset, 0);
        check("arst_wrap", 0, wrap, 0);
        check("arst_busy", 0, sweep_busy, 0);
        check("arst_done", 0, sweep_done, 0);
        #2;
        rst = 1'b1;
        incr = 16'h4000;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("post_addr", k, addr, (k * 'h40) & 'hFF);
            check("post_wrap", k, wrap, (k == 4) ? 1 : 0);
            check("post_offset", k, offset, 0);
            check("post_busy", k, sweep_busy, 0);
            check("post_done", k, sweep_done, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
